// File: rtl/brick_grid_pkg.sv
// Shared types, grid geometry and level pattern for the brick field.
package brick_grid_pkg;

  localparam int GRID_COLS  = 20;
  localparam int GRID_ROWS  = 15;
  localparam int TILE_BITS  = 5;
  localparam int TILE_SIZE  = 32;
  localparam int NUM_CELLS  = GRID_COLS * GRID_ROWS;
  localparam int ADDR_W     = 9;

  typedef enum logic [1:0] {INIT, RUN, APPLY} state_t;
  typedef logic [1:0]        health_t;
  typedef logic [ADDR_W-1:0] cell_addr_t;

  localparam health_t    MAX_HEALTH = 2'd2;
  localparam cell_addr_t LAST_CELL  = cell_addr_t'(NUM_CELLS - 1);
  localparam logic [4:0] COL_LAST   = 5'(GRID_COLS - 1);
  localparam logic [4:0] COL_LIMIT5 = 5'(GRID_COLS);
  localparam logic [5:0] COL_LIMIT6 = 6'(GRID_COLS);
  localparam logic [5:0] ROW_LIMIT6 = 6'(GRID_ROWS);

  // Fresh level: rows 2..6 hold full-health bricks, everything else is empty.
  function automatic health_t level_health(input logic [3:0] row, input logic [4:0] col);
    return (row >= 4'd2 && row <= 4'd6 && col < COL_LIMIT5) ? MAX_HEALTH : 2'd0;
  endfunction

  function automatic cell_addr_t cell_index(input logic [3:0] row, input logic [4:0] col);
    return cell_addr_t'(row) * cell_addr_t'(GRID_COLS) + cell_addr_t'(col);
  endfunction

endpackage

// File: rtl/brick_grid_controller_mem.sv
// Brick health storage: one combinational lookup port for the pixel path and
// one read-modify-write port shared by level init and damage application.
module brick_health_mem
  import brick_grid_pkg::*;
(
  input  logic       clk,
  input  cell_addr_t lk_addr_i,
  output health_t    lk_data_o,
  input  cell_addr_t rmw_addr_i,
  output health_t    rmw_rdata_o,
  input  logic       wr_en_i,
  input  health_t    wr_data_i
);

  health_t mem_q [NUM_CELLS];

  assign lk_data_o   = mem_q[lk_addr_i];
  assign rmw_rdata_o = mem_q[rmw_addr_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[rmw_addr_i] <= wr_data_i;
  end

endmodule

// File: rtl/brick_grid_controller.sv
// Brick field owner: pixel lookup, collision capture, per-frame damage, level init.
//   state | meaning
//   INIT  | writing the level pattern, one cell per cycle
//   RUN   | pixel lookup live, collisions captured
//   APPLY | one-cycle damage of the pending brick
module brick_grid_controller
  import brick_grid_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        collision,
  input  logic        levelLoad,
  output logic        insideBrick,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        brickHit,
  output logic [4:0]  hitCol,
  output logic [3:0]  hitRow,
  output logic [8:0]  bricksLeft,
  output logic        levelCleared,
  output logic        busy
);

  state_t     state_q, state_d;
  cell_addr_t idx_q, idx_d;
  logic [4:0] init_col_q, init_col_d;
  logic [3:0] init_row_q, init_row_d;
  logic       pend_q, pend_d;
  logic [4:0] pend_col_q, pend_col_d;
  logic [3:0] pend_row_q, pend_row_d;
  logic [8:0] bricks_q, bricks_d;
  logic       hit_q, hit_d;
  logic [4:0] hit_col_q, hit_col_d;
  logic [3:0] hit_row_q, hit_row_d;
  logic       inside_q, inside_d;
  logic [4:0] offx_q, offy_q;
  logic       clr_q, clr_d;

  logic       p1_valid_q, p2_valid_q;
  logic [4:0] p1_col_q, p2_col_q;
  logic [3:0] p1_row_q, p2_row_q;

  logic [5:0] px_col, px_row;
  logic       in_grid, px_valid;
  cell_addr_t lk_addr, rmw_addr;
  health_t    lk_data, rmw_rdata, wr_data;
  logic       wr_en;

  assign px_col   = pixelX[10:TILE_BITS];
  assign px_row   = pixelY[10:TILE_BITS];
  assign in_grid  = (px_col < COL_LIMIT6) && (px_row < ROW_LIMIT6);
  assign px_valid = in_grid && (state_q != INIT);
  assign lk_addr  = in_grid ? cell_index(px_row[3:0], px_col[4:0]) : '0;

  brick_health_mem u_mem (
    .clk         (clk),
    .lk_addr_i   (lk_addr),
    .lk_data_o   (lk_data),
    .rmw_addr_i  (rmw_addr),
    .rmw_rdata_o (rmw_rdata),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    init_col_d = init_col_q;
    init_row_d = init_row_q;
    pend_d     = pend_q;
    pend_col_d = pend_col_q;
    pend_row_d = pend_row_q;
    bricks_d   = bricks_q;
    hit_d      = 1'b0;
    hit_col_d  = hit_col_q;
    hit_row_d  = hit_row_q;
    rmw_addr   = cell_index(pend_row_q, pend_col_q);
    wr_en      = 1'b0;
    wr_data    = level_health(init_row_q, init_col_q);

    if (levelLoad) begin
      state_d    = INIT;
      idx_d      = '0;
      init_col_d = '0;
      init_row_d = '0;
      pend_d     = 1'b0;
      bricks_d   = '0;
    end else begin
      case (state_q)
        INIT: begin
          rmw_addr = idx_q;
          wr_en    = 1'b1;
          if (wr_data != 2'd0) bricks_d = bricks_q + 9'd1;
          if (idx_q == LAST_CELL) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + 9'd1;
            if (init_col_q == COL_LAST) begin
              init_col_d = '0;
              init_row_d = init_row_q + 4'd1;
            end else begin
              init_col_d = init_col_q + 5'd1;
            end
          end
        end
        RUN: begin
          // The pending cell is read here so brickHit is already valid during APPLY.
          if (startOfFrame && pend_q) begin
            state_d = APPLY;
            if (rmw_rdata != 2'd0) begin
              hit_d     = 1'b1;
              hit_col_d = pend_col_q;
              hit_row_d = pend_row_q;
            end
          end else if (collision && p2_valid_q && !pend_q) begin
            pend_d     = 1'b1;
            pend_col_d = p2_col_q;
            pend_row_d = p2_row_q;
          end
        end
        APPLY: begin
          if (rmw_rdata != 2'd0) begin
            wr_en   = 1'b1;
            wr_data = rmw_rdata - 2'd1;
            if (rmw_rdata == 2'd1) bricks_d = bricks_q - 9'd1;
          end
          pend_d  = 1'b0;
          state_d = RUN;
        end
        default: state_d = INIT;
      endcase
    end

    inside_d = px_valid && (lk_data != 2'd0);
    clr_d    = (state_q == RUN) && (state_d == RUN) && (bricks_q == 9'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= INIT;
      idx_q      <= '0;
      init_col_q <= '0;
      init_row_q <= '0;
      pend_q     <= 1'b0;
      pend_col_q <= '0;
      pend_row_q <= '0;
      bricks_q   <= '0;
      hit_q      <= 1'b0;
      hit_col_q  <= '0;
      hit_row_q  <= '0;
      inside_q   <= 1'b0;
      offx_q     <= '0;
      offy_q     <= '0;
      clr_q      <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_col_q   <= '0;
      p1_row_q   <= '0;
      p2_valid_q <= 1'b0;
      p2_col_q   <= '0;
      p2_row_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      init_col_q <= init_col_d;
      init_row_q <= init_row_d;
      pend_q     <= pend_d;
      pend_col_q <= pend_col_d;
      pend_row_q <= pend_row_d;
      bricks_q   <= bricks_d;
      hit_q      <= hit_d;
      hit_col_q  <= hit_col_d;
      hit_row_q  <= hit_row_d;
      inside_q   <= inside_d;
      offx_q     <= pixelX[TILE_BITS-1:0];
      offy_q     <= pixelY[TILE_BITS-1:0];
      clr_q      <= clr_d;
      // Two stages to line the tile up with the renderer's collision flag.
      p1_valid_q <= px_valid;
      p1_col_q   <= px_col[4:0];
      p1_row_q   <= px_row[3:0];
      p2_valid_q <= p1_valid_q;
      p2_col_q   <= p1_col_q;
      p2_row_q   <= p1_row_q;
    end
  end

  assign insideBrick  = inside_q;
  assign offsetX      = {6'd0, offx_q};
  assign offsetY      = {6'd0, offy_q};
  assign brickHit     = hit_q;
  assign hitCol       = hit_col_q;
  assign hitRow       = hit_row_q;
  assign bricksLeft   = bricks_q;
  assign levelCleared = clr_q;
  assign busy         = (state_q == INIT);

endmodule
